// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment digit scanner.
// No logic here; latency and backpressure are defined by the users of the package.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] AN_OFF       = 4'b1111;
  localparam int         SHOW_CYC_DEF = 25000;
  localparam int         GAP_CYC_DEF  = 16;

  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

  // Digit i goes dark when it and every more-significant nibble are zero.
  function automatic logic lead_blank(input logic [15:0] d, input logic [1:0] i);
    case (i)
      2'd3:    return d[15:12] == 4'h0;
      2'd2:    return d[15:8] == 8'h0;
      2'd1:    return d[15:4] == 12'h0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for the digit scanner: value/load/control inputs, anode/nibble outputs.
// Plain wires; no handshake, load is a fire-and-forget strobe.
interface seg_scan_ctrl_if;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  an;
  logic [3:0]  x;
  logic        dp;
  logic        pending;
  logic        frame_done;

  modport master (
    output enable, value, load, dp_in, lz_en,
    input  an, x, dp, pending, frame_done
  );

  modport slave (
    input  enable, value, load, dp_in, lz_en,
    output an, x, dp, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Phase counter for the scanner: clear beats load beats increment, one-cycle update.
// No backpressure; the owner decides every cycle which action applies.
module scan_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (inc) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes four hex digits onto one anode bus with blank gaps; all outputs registered.
// No backpressure: load is accepted every cycle, latest value wins until the frame boundary.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SHOW_CYC = SHOW_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int            TW        = tmr_width(SHOW_CYC, GAP_CYC);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          tmr_clr, wrap, commit, armed;
  logic [15:0]   display, disp_nxt, pbuf, pbuf_nxt;
  logic          pend, pend_nxt;
  logic [3:0]    an_q, an_nxt, x_q, x_nxt;
  logic          dp_q, dp_nxt, fd_q, fd_nxt;

  scan_timer #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .ld     (1'b0),
    .inc    (1'b1),
    .ld_val ('0),
    .cnt    (tmr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      armed   <= 1'b0;
      display <= 16'h0;
      pbuf    <= 16'h0;
      pend    <= 1'b0;
      an_q    <= AN_OFF;
      x_q     <= 4'h0;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      armed   <= 1'b1;
      display <= disp_nxt;
      pbuf    <= pbuf_nxt;
      pend    <= pend_nxt;
      an_q    <= an_nxt;
      x_q     <= x_nxt;
      dp_q    <= dp_nxt;
      fd_q    <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_clr   = 1'b1;
    wrap      = 1'b0;
    disp_nxt  = display;
    pbuf_nxt  = pbuf;
    pend_nxt  = pend;
    an_nxt    = AN_OFF;
    dp_nxt    = 1'b1;
    x_nxt     = x_q;

    // armed holds off the first SHOW until the second edge after reset release
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
      idx_nxt   = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed) begin
            state_nxt = ST_SHOW;
            idx_nxt   = 2'd0;
          end
        end
        ST_SHOW: begin
          if (tmr == SHOW_LAST) state_nxt = ST_GAP;
          else                  tmr_clr   = 1'b0;
        end
        ST_GAP: begin
          if (tmr == GAP_LAST) begin
            state_nxt = ST_SHOW;
            idx_nxt   = idx + 2'd1;
            wrap      = (idx == 2'd3);
          end else begin
            tmr_clr = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    commit = wrap || ((state == ST_IDLE) && pend);
    if (commit) begin
      disp_nxt = bus.load ? bus.value : pbuf;
      pend_nxt = 1'b0;
    end else if (bus.load) begin
      pbuf_nxt = bus.value;
      pend_nxt = 1'b1;
    end

    // Look ahead one cycle so the registered pulse lands on the last GAP cycle of digit 3
    tmr_nxt = tmr_clr ? '0 : tmr + TW'(1);
    fd_nxt  = (state_nxt == ST_GAP) && (idx_nxt == 2'd3) && (tmr_nxt == GAP_LAST);

    if (state_nxt == ST_SHOW) begin
      x_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
      if (!(bus.lz_en && lead_blank(disp_nxt, idx_nxt))) begin
        an_nxt = ~(4'b0001 << idx_nxt);
        dp_nxt = ~bus.dp_in[idx_nxt];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.x          = x_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pend;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a frame-position model checked every cycle.
module tb_seg_scan_ctrl;

  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G;
  localparam int F = 4 * P;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SHOW_CYC(S), .GAP_CYC(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: position within a 24-cycle frame; digit = pos/P, lit while pos%P < S.
  bit          m_run  = 1'b0;
  bit          m_arm  = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_commit;
  int          m_pos  = 0;
  int          d;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pbuf = 16'h0;
  logic [3:0]  e_an   = 4'hF;
  logic [3:0]  e_x    = 4'h0;
  logic        e_dp   = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_arm = 1'b0; m_pend = 1'b0; m_pos = 0;
      m_disp = 16'h0; m_pbuf = 16'h0;
      e_an = 4'hF; e_x = 4'h0; e_dp = 1'b1;
    end else begin
      m_commit = (m_run && bus.enable && m_pos == F - 1) || (!m_run && m_pend);
      if (m_commit) begin
        m_disp = bus.load ? bus.value : m_pbuf;
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_pbuf = bus.value;
        m_pend = 1'b1;
      end
      if (!bus.enable) begin
        m_run = 1'b0; m_pos = 0;
      end else if (!m_run) begin
        if (m_arm) begin m_run = 1'b1; m_pos = 0; end
      end else begin
        m_pos = (m_pos + 1) % F;
      end
      m_arm = 1'b1;
      e_an = 4'hF;
      e_dp = 1'b1;
      if (m_run) begin
        d   = m_pos / P;
        e_x = m_disp[4*d +: 4];
        if ((m_pos % P) < S && !(bus.lz_en && d > 0 && (m_disp >> (4*d)) == 16'h0)) begin
          e_an = ~(4'b0001 << d);
          e_dp = ~bus.dp_in[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_an", 16'(bus.an), 16'(e_an));
      chk("model_x", 16'(bus.x), 16'(e_x));
      chk("model_dp", 16'(bus.dp), 16'(e_dp));
      chk("model_pending", 16'(bus.pending), 16'(m_pend));
      chk("model_frame_done", 16'(bus.frame_done), 16'(m_run && m_pos == F - 1));
    end
  end

  logic [3:0] an_seq [8] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111};
  logic [3:0] x_seq  [8] = '{4'h4, 4'h4, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1};
  int         at_c   [8] = '{0, 4, 6, 10, 12, 16, 18, 22};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.enable = 1'b0; bus.value = 16'h0; bus.load = 1'b0; bus.dp_in = 4'h0; bus.lz_en = 1'b0;
    #2 rst_n = 1'b0;
    #5;
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_x", 16'(bus.x), 16'h0);
    chk("rst_dp", 16'(bus.dp), 16'h1);
    chk("rst_pending", 16'(bus.pending), 16'h0);
    chk("rst_frame_done", 16'(bus.frame_done), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 1234
    @(negedge clk); bus.load = 1'b1; bus.value = 16'h1234;
    @(negedge clk); chk("idle_pending_set", 16'(bus.pending), 16'h1); bus.load = 1'b0;
    @(negedge clk); chk("idle_commit", 16'(bus.pending), 16'h0); bus.enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (c % 24 == at_c[k]) begin
          chk("seq_an", 16'(bus.an), 16'(an_seq[k]));
          chk("seq_x", 16'(bus.x), 16'(x_seq[k]));
        end
      end
      if (c % 24 == 23) chk("seq_frame_done", 16'(bus.frame_done), 16'h1);
      if (c % 24 == 22) chk("seq_no_frame_done", 16'(bus.frame_done), 16'h0);
    end

    // Reload 0050 from IDLE with leading-zero suppression
    bus.enable = 1'b0;
    @(negedge clk); bus.load = 1'b1; bus.value = 16'h0050;
    @(negedge clk); bus.load = 1'b0; bus.lz_en = 1'b1; bus.dp_in = 4'b0101; bus.enable = 1'b1;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk);
      case (c)
        0:  begin chk("lz_d0_an", 16'(bus.an), 16'hE); chk("lz_d0_x", 16'(bus.x), 16'h0);
                  chk("lz_d0_dp", 16'(bus.dp), 16'h0); end
        6:  begin chk("lz_d1_an", 16'(bus.an), 16'hD); chk("lz_d1_x", 16'(bus.x), 16'h5);
                  chk("lz_d1_dp", 16'(bus.dp), 16'h1); end
        12: begin chk("lz_d2_an", 16'(bus.an), 16'hF); chk("lz_d2_dp", 16'(bus.dp), 16'h1); end
        18: chk("lz_d3_an", 16'(bus.an), 16'hF);
        33: chk("mid_pending", 16'(bus.pending), 16'h1);
        36: begin chk("mid_old_an", 16'(bus.an), 16'hB); chk("mid_old_x", 16'(bus.x), 16'h0); end
        47: begin chk("mid_fd", 16'(bus.frame_done), 16'h1); chk("mid_fd_pending", 16'(bus.pending), 16'h1); end
        48: begin chk("new_pending", 16'(bus.pending), 16'h0); chk("new_d0_x", 16'(bus.x), 16'hD);
                  chk("new_d0_an", 16'(bus.an), 16'hE); end
        54: chk("new_d1_x", 16'(bus.x), 16'hC);
        60: chk("new_d2_x", 16'(bus.x), 16'hB);
        66: chk("new_d3_x", 16'(bus.x), 16'hA);
        71: chk("co_fd", 16'(bus.frame_done), 16'h1);
        72: begin chk("co_pending", 16'(bus.pending), 16'h0); chk("co_d0_x", 16'(bus.x), 16'hC);
                  chk("co_d0_an", 16'(bus.an), 16'hE); end
        78: begin chk("co_d1_x", 16'(bus.x), 16'h3); chk("co_d1_an", 16'(bus.an), 16'hD); end
        86: begin chk("abort_an", 16'(bus.an), 16'hF); chk("abort_fd", 16'(bus.frame_done), 16'h0); end
        91: begin chk("restart_an", 16'(bus.an), 16'hE); chk("restart_x", 16'(bus.x), 16'hC); end
        95: chk("restart_no_fd", 16'(bus.frame_done), 16'h0);
        98: chk("pre_rst_an", 16'(bus.an), 16'hD);
        default: ;
      endcase
      case (c)
        23: begin bus.lz_en = 1'b0; bus.dp_in = 4'h0; end
        32: begin bus.load = 1'b1; bus.value = 16'hABCD; end
        33: bus.load = 1'b0;
        71: begin bus.load = 1'b1; bus.value = 16'h5A3C; end
        72: bus.load = 1'b0;
        85: bus.enable = 1'b0;
        90: bus.enable = 1'b1;
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of SHOW
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 16'(bus.an), 16'hF);
    chk("async_dp", 16'(bus.dp), 16'h1);
    chk("async_x", 16'(bus.x), 16'h0);
    chk("async_pending", 16'(bus.pending), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("arm_first_edge_an", 16'(bus.an), 16'hF);
    @(negedge clk); chk("arm_second_edge_an", 16'(bus.an), 16'hE);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
